// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round constants, sequencer states and
// the word-level helpers used by the forward key expansion.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2,
        CALC = 2'd3
    } ks_state_e;

    localparam logic [3:0] LAST_IDX = 4'd10;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx < 4'd10) begin
            r = RCON[idx];
        end
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // One schedule step: t already carries SubWord(RotWord(w3)) ^ rcon.
    function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [31:0] t);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_ks_issuer_if.sv
// Handshake bundle of the key-schedule issuer: SubWord request channel to the
// S-box unit and round-key channel to the round datapath.
interface aes128_ks_issuer_if;
    logic         sw_valid;
    logic         sw_dec;
    logic [31:0]  sw_rs1;
    logic         sw_ready;
    logic [31:0]  sw_rd;

    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk;

    modport master (
        output sw_valid, sw_dec, sw_rs1,
        input  sw_ready, sw_rd,
        output rk_valid, rk_idx, rk,
        input  rk_ready
    );

    modport slave (
        input  sw_valid, sw_dec, sw_rs1,
        output sw_ready, sw_rd,
        input  rk_valid, rk_idx, rk,
        output rk_ready
    );
endinterface

// File: rtl/aes128_ks_step.sv
// Combinational CALC datapath: folds the round constant into the SubWord
// result and chains the four word XORs to form the next round key.
module aes128_ks_step
    import aes_pkg::*;
(
    input  logic [127:0] kreg,
    input  logic [31:0]  treg,
    input  logic [3:0]   idx,
    output logic [127:0] knext
);

    logic [31:0] t;

    assign t     = treg ^ {rcon_of(idx), 24'h000000};
    assign knext = ks_step(kreg, t);

endmodule

// File: rtl/aes128_ks_issuer.sv
// AES-128 forward key-expansion sequencer: issues SubWord requests to the
// shared S-box unit and streams round keys 0..10 over a valid/ready channel.
module aes128_ks_issuer
    import aes_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 64,
    parameter int unsigned WAIT_W     = 8
) (
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                start,
    input  logic [127:0]        key,
    output logic                busy,
    output logic                err,
    aes128_ks_issuer_if.master  bus
);

    localparam logic [WAIT_W-1:0] WAIT_LIM_W = WAIT_W'(WAIT_LIMIT);
    localparam bit                WD_EN      = (WAIT_LIMIT != 0);

    ks_state_e         state;
    logic [127:0]      kreg;
    logic [127:0]      knext;
    logic [31:0]       treg;
    logic [3:0]        idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    logic              sw_valid_q;
    logic [31:0]       sw_rs1_q;
    logic              rk_valid_q;
    logic [3:0]        rk_idx_q;
    logic [127:0]      rk_q;

    aes128_ks_step u_step (
        .kreg  (kreg),
        .treg  (treg),
        .idx   (idx),
        .knext (knext)
    );

    // Saturate so a stalled unit can never wrap the counter back below the limit.
    always_comb begin
        wait_nxt = wait_cnt;
        if (wait_cnt != '1) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            sw_valid_q <= 1'b0;
            sw_rs1_q   <= 32'h0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= 4'd0;
            rk_q       <= 128'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= 4'd0;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        rk_valid_q <= 1'b1;
                        rk_idx_q   <= 4'd0;
                        rk_q       <= key;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.rk_ready) begin
                        rk_valid_q <= 1'b0;
                        rk_q       <= 128'h0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            sw_valid_q <= 1'b1;
                            sw_rs1_q   <= rot_word(kreg[31:0]);
                            state      <= SUB;
                        end
                    end
                end
                SUB: begin
                    // Request stays untouched until the unit answers, even after a timeout.
                    if (bus.sw_ready) begin
                        sw_valid_q <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= CALC;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (WD_EN && (wait_nxt == WAIT_LIM_W)) begin
                            err <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    idx        <= idx + 4'd1;
                    rk_valid_q <= 1'b1;
                    rk_idx_q   <= idx + 4'd1;
                    rk_q       <= knext;
                    state      <= EMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Key and SubWord result registers: pure data, no reset needed.
    always_ff @(posedge g_clk) begin
        if ((state == IDLE) && start) begin
            kreg <= key;
        end else if (state == CALC) begin
            kreg <= knext;
        end
        if ((state == SUB) && bus.sw_ready) begin
            treg <= bus.sw_rd;
        end
    end

    assign bus.sw_valid = sw_valid_q;
    assign bus.sw_dec   = 1'b0;
    assign bus.sw_rs1   = sw_rs1_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.rk       = rk_q;

endmodule

// File: doc/aes128_ks_issuer.md
Name: aes128_ks_issuer

Overview:
- AES-128 forward key-expansion sequencer.
- Acts as the initiator side of the SubWord valid/ready interface served by the team's multi-cycle AES SubWord unit (aes_v1): it drives valid/dec/rs1 and consumes rd.
- Expands a 128-bit cipher key into round keys 0..10 and streams them to a consumer over a second valid/ready handshake.
- Sits between key-load logic and the round datapath.

Parameters:
- WAIT_LIMIT, 64: cycles a SubWord request may stay outstanding before the sticky error flag sets; 0 disables the watchdog.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- g_clk  in  1  clock; all state changes on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin expansion; key sampled in the same cycle.
- key  in  128  cipher key; w0=key[127:96] .. w3=key[31:0].
- busy  out  1  high from the accepted start until the last round key is accepted.
- sw_valid  out  1  SubWord request valid.
- sw_dec  out  1  constant 0 (forward S-box only).
- sw_rs1  out  32  SubWord operand.
- sw_ready  in  1  SubWord unit finished; result valid when sw_valid && sw_ready.
- sw_rd  in  32  SubWord result.
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_idx  out  4  round index 0..10.
- rk  out  128  round key, same word order as key.
- err  out  1  sticky watchdog flag; cleared only by reset or an accepted start.

Behaviour:
- Reset (synchronous, active-high): every output is 0, the state is IDLE and all counters are 0. Reset overrides an in-flight request; sw_valid drops in the following cycle.
- States and transitions:
  - IDLE: on start, load key into kreg, set idx=0, set busy, clear err, go to EMIT. start outside IDLE is ignored.
  - EMIT: rk_valid=1, rk=kreg, rk_idx=idx, both held stable until rk_ready. On acceptance: if idx==10, go to IDLE and drop busy in the same edge; otherwise go to SUB.
  - SUB: sw_valid=1, sw_rs1 = RotWord(w3) = {w3[23:0],w3[31:24]}. sw_valid, sw_dec and sw_rs1 are never changed while sw_valid && !sw_ready. The cycle with sw_valid && sw_ready captures sw_rd into treg and moves to CALC; sw_valid is 0 in the next cycle. sw_ready seen in the first SUB cycle (a zero-wait unit) is legal.
  - CALC (1 cycle):
    - t = treg ^ {rcon[idx],24'h0}
    - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
    - kreg updates, idx increments, go to EMIT.
- rcon[0..9] = 01,02,04,08,10,20,40,80,1B,36 (hex).
- Latency: start to rk_valid is 1 cycle. Each following key takes 1 (EMIT accept) + N_sw (SubWord cycles, at least 1) + 1 (CALC) cycles, assuming rk_ready is constantly high.
- Watchdog: in SUB the wait counter increments every cycle that sw_ready is low and resets on leaving SUB. When it reaches WAIT_LIMIT (and WAIT_LIMIT != 0), err sets. The request is still held; the valid/ready protocol is never broken by a timeout.
- Backpressure: rk_ready low holds EMIT indefinitely with rk, rk_idx and rk_valid stable; no overwrite occurs.
- Reset asserted mid-SUB or mid-EMIT: return to IDLE next cycle, and no partial round key is ever presented.

Decomposition:
- Shared package aes_pkg holds:
  - the rcon table constant
  - the state enumeration (IDLE, EMIT, SUB, CALC)
  - a RotWord function
  - a 4-word key-schedule step function (t, kreg -> kreg')
- Natural sub-module: aes128_ks_step, the combinational CALC datapath. Everything else stays in the top.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, instant SubWord model:
  - first request sw_rs1=cf4f3c09; model returns 8a84eb01
  - rk_idx=1 carries rk=a0fafe1788542cb123a339392a6c7605
  - rk_idx=10 carries rk=d014f9a8c9ee2589e13f0cc8b6630ca6
  - busy falls after the idx 10 acceptance
- SubWord model with random 1-7 cycle delay: identical 11 keys; a protocol check confirms sw_valid/sw_rs1/sw_dec are stable while waiting and sw_dec=0 throughout.
- rk_ready held low for 20 cycles at idx=3: rk and rk_idx stay stable, no SubWord request is issued, and the sequence resumes correctly afterwards.
- start pulsed with a different key at idx=5: ignored; the output sequence still matches the original key.
- g_reset asserted during SUB of idx=4: next cycle all outputs are 0 and the state is IDLE. A subsequent start produces the full sequence from idx=0.
- WAIT_LIMIT=4, sw_ready withheld 10 cycles: err rises on the 4th wait cycle and sw_valid is still held. After sw_ready arrives, expansion completes; err clears on the next start.
